// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl: sequential unsigned 32x32->64 shift-add multiplier (optional macro MUL_ZERO_BYPASS_EN)
module full_adder_32bit (
   input  logic [31:0] A_i,
   input  logic [31:0] Y_i,
   input  logic        C_i,
   output logic [31:0] S_o,
   output logic        c_o
);
   assign {c_o, S_o} = {1'b0, A_i} + {1'b0, Y_i} + {32'b0, C_i};
endmodule

module mul_seq_ctrl #(
   parameter int ITER = 32
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        start_i,
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   input  logic        flush_i,
   output logic        busy_o,
   output logic        done_o,
   output logic [63:0] product_o
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t      state, state_nx;
   logic [31:0] mcand, mplier, hi, lo, s, y;
   logic [5:0]  cnt;
   logic [63:0] prod_q;
   logic        c, accept, last, zero;
   assign y = mplier[0] ? mcand : 32'h0;
   full_adder_32bit u_add (.A_i(hi), .Y_i(y), .C_i(1'b0), .S_o(s), .c_o(c));
   assign accept = start_i && !flush_i && (state != RUN);
   assign last   = cnt == 6'(ITER - 1);
`ifdef MUL_ZERO_BYPASS_EN
   assign zero = (a_i == 32'h0) || (b_i == 32'h0);
`else
   assign zero = 1'b0;
`endif
   assign busy_o    = state == RUN;
   assign done_o    = state == DONE;
   assign product_o = prod_q;
   // next state: flush wins, RUN counts down to DONE, a new accept restarts from IDLE/DONE
   always_comb begin
      state_nx = IDLE;
      if (flush_i) state_nx = IDLE;
      else if (state == RUN) state_nx = last ? DONE : RUN;
      else if (accept) state_nx = zero ? DONE : RUN;
   end
   // datapath: load operands on accept, one shift-add step per RUN cycle, capture product on the last step
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state  <= IDLE;
         mcand  <= '0;
         mplier <= '0;
         hi     <= '0;
         lo     <= '0;
         cnt    <= '0;
         prod_q <= '0;
      end else begin
         state <= state_nx;
         if (accept) begin
            mcand  <= a_i;
            mplier <= b_i;
            hi     <= '0;
            lo     <= '0;
            cnt    <= '0;
            if (zero) prod_q <= '0;
         end else if (state == RUN) begin
            hi     <= {c, s[31:1]};
            lo     <= {s[0], lo[31:1]};
            mplier <= mplier >> 1;
            cnt    <= cnt + 6'd1;
            if (last && !flush_i) prod_q <= {c, s, lo[31:1]};
         end
      end
   end
endmodule

// File: tb/tb_mul_seq_ctrl.sv
// tb_mul_seq_ctrl: directed checks of mul_seq_ctrl latency, results, flush and reset
module tb_mul_seq_ctrl;
   logic        clk = 0, rst_n = 1, start = 0, flush = 0;
   logic [31:0] a = 0, b = 0;
   logic        busy, done;
   logic [63:0] product;
   int          total = 0, bad = 0;
   int          lat, bsy, nd;

   mul_seq_ctrl dut (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start), .a_i(a), .b_i(b),
      .flush_i(flush), .busy_o(busy), .done_o(done), .product_o(product)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // drive a request from a negedge; returns just after the accepting edge
   task automatic issue(input logic [31:0] x, input logic [31:0] z);
      a = x;
      b = z;
      start = 1;
      @(posedge clk);
      #1 start = 0;
   endtask

   // cycle index (1 = cycle after accept) of the done pulse, busy cycles seen before it
   task automatic wait_done(output int k, output int n);
      bit got;
      got = 0;
      k = 0;
      n = 0;
      while (k < 80 && !got) begin
         @(negedge clk);
         k++;
         if (busy) n++;
         if (done) got = 1;
      end
      if (!got) k = -1;
   endtask

   task automatic count_done(input int cycles, output int n);
      n = 0;
      repeat (cycles) begin
         @(negedge clk);
         if (done) n++;
      end
   endtask

   initial begin
      #2 rst_n = 0;
      #1;
      check("rst_busy", 64'(busy), 0);
      check("rst_done", 64'(done), 0);
      check("rst_prod", product, 0);
      repeat (3) @(negedge clk);
      rst_n = 1;
      count_done(10, nd);
      check("idle_no_done", nd, 0);

      issue(3, 5);
      wait_done(lat, bsy);
      check("3x5_lat", lat, 33);
      check("3x5_busy", bsy, 32);
      check("3x5_prod", product, 64'd15);
      @(negedge clk);
      check("3x5_pulse", 64'(done), 0);
      check("3x5_hold", product, 64'd15);

      issue(32'hFFFFFFFF, 32'hFFFFFFFF);
      wait_done(lat, bsy);
      check("ff_lat", lat, 33);
      check("ff_prod", product, 64'hFFFFFFFE_00000001);

      @(negedge clk);
      issue(7, 6);
      wait_done(lat, bsy);
      check("7x6_prod", product, 64'd42);
      @(negedge clk);
      issue(9, 9);
      repeat (4) @(negedge clk);
      a = 1;
      b = 1;
      start = 1;
      @(negedge clk);
      start = 0;
      repeat (4) @(negedge clk);
      check("9x9_busy_mid", 64'(busy), 1);
      flush = 1;
      @(posedge clk);
      #1 flush = 0;
      @(negedge clk);
      check("flush_busy", 64'(busy), 0);
      count_done(45, nd);
      check("flush_no_done", nd, 0);
      check("flush_prod", product, 64'd42);
      issue(2, 2);
      wait_done(lat, bsy);
      check("2x2_lat", lat, 33);
      check("2x2_prod", product, 64'd4);

      @(negedge clk);
      issue(32'h10000, 32'h10000);
      wait_done(lat, bsy);
      check("b2b1_prod", product, 64'h1_00000000);
      issue(32'h12345678, 32'h9ABCDEF0);
      wait_done(lat, bsy);
      check("b2b2_lat", lat, 33);
      check("b2b2_busy", bsy, 32);
      check("b2b2_prod", product, 64'h0B00EA4E_242D2080);

      @(negedge clk);
      issue(0, 32'h1234);
      wait_done(lat, bsy);
`ifdef MUL_ZERO_BYPASS_EN
      check("zero_lat", lat, 1);
      check("zero_busy", bsy, 0);
`else
      check("zero_lat", lat, 33);
      check("zero_busy", bsy, 32);
`endif
      check("zero_prod", product, 0);

      @(negedge clk);
      issue(11, 13);
      wait_done(lat, bsy);
      check("11x13_prod", product, 64'd143);
      @(negedge clk);
      issue(100, 200);
      repeat (5) @(negedge clk);
      #2 rst_n = 0;
      #1;
      check("arst_busy", 64'(busy), 0);
      check("arst_done", 64'(done), 0);
      check("arst_prod", product, 0);
      @(negedge clk);
      rst_n = 1;
      count_done(45, nd);
      check("arst_no_done", nd, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
